// File: rtl/spi_bridge_pkg.sv
// Shared constants, FSM state type and sizing helper for the SPI pixel bridge.
package spi_bridge_pkg;

  localparam int DEF_PIXEL_BITS  = 24;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } bridge_state_t;

  // Width needed to hold an occupancy value of 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spi_pixel_bridge_fifo.sv
// Synchronous pixel FIFO; when full, a pop in the same cycle frees room for a push.
module pixel_fifo
  import spi_bridge_pkg::*;
#(
  parameter int WIDTH = DEF_PIXEL_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int LW    = level_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign level_d = level_q + LW'(do_push) - LW'(do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/sync_cell.sv
// Common multi-flop synchroniser for a single asynchronous input bit.
module sync_cell #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_pixel_bridge.sv
// SPI mode-0 slave that exchanges PIXEL_BITS-wide words with the core through
// an input FIFO (received pixels) and an output FIFO (results shifted out on SDO).
module spi_pixel_bridge
  import spi_bridge_pkg::*;
#(
  parameter int PIXEL_BITS  = DEF_PIXEL_BITS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                             clk_i,
  input  logic                             nreset_i,
  input  logic                             spi_sck_i,
  input  logic                             spi_cs_i,
  input  logic                             spi_sdi_i,
  output logic                             spi_sdo_o,
  output logic                             spi_sdo_oe_o,
  output logic [PIXEL_BITS-1:0]            px_o,
  output logic                             px_valid_o,
  input  logic                             px_ready_i,
  input  logic [PIXEL_BITS-1:0]            res_i,
  input  logic                             res_valid_i,
  output logic                             res_ready_o,
  input  logic                             clear_i,
  output logic                             overrun_o,
  output logic                             underrun_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  in_level_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  out_level_o
);

  localparam int LW = level_width(FIFO_DEPTH);
  localparam int CW = $clog2(PIXEL_BITS + 1);

  logic sck_s, cs_s, sdi_s;
  logic sck_prev_q, cs_prev_q;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  // CS chain resets high so the bridge comes out of reset deselected.
  sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_ni(nreset_i), .d_i(spi_sck_i), .q_o(sck_s));
  sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(clk_i), .rst_ni(nreset_i), .d_i(spi_cs_i), .q_o(cs_s));
  sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk_i(clk_i), .rst_ni(nreset_i), .d_i(spi_sdi_i), .q_o(sdi_s));

  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_s;
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;

  bridge_state_t         state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PIXEL_BITS-1:0] rx_q, rx_d, tx_q, tx_d;
  logic                  push_pend_q, push_pend_d;
  logic                  overrun_q, overrun_d, underrun_q, underrun_d;
  logic                  tx_load;

  logic                  in_full, in_empty, in_pop;
  logic                  out_full, out_empty;
  logic [PIXEL_BITS-1:0] out_head;
  logic [LW-1:0]         in_level, out_level;

  assign in_pop = px_ready_i & ~in_empty;

  pixel_fifo #(.WIDTH(PIXEL_BITS), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk_i(clk_i), .rst_ni(nreset_i),
    .push_i(push_pend_q), .data_i(rx_q), .pop_i(px_ready_i),
    .data_o(px_o), .full_o(in_full), .empty_o(in_empty), .level_o(in_level));

  pixel_fifo #(.WIDTH(PIXEL_BITS), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk_i(clk_i), .rst_ni(nreset_i),
    .push_i(res_valid_i & ~out_full), .data_i(res_i), .pop_i(tx_load),
    .data_o(out_head), .full_o(out_full), .empty_o(out_empty), .level_o(out_level));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    push_pend_d = 1'b0;
    tx_load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          tx_load   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (sck_rise) begin
          rx_d = {rx_q[PIXEL_BITS-2:0], sdi_s};
          if (bit_cnt_q == CW'(PIXEL_BITS - 1)) begin
            bit_cnt_d   = '0;
            push_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == '0) tx_load = 1'b1;
          else                 tx_d    = {tx_q[PIXEL_BITS-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
    // An empty output FIFO sends zeros; the pop request is ignored by the FIFO.
    if (tx_load) tx_d = out_empty ? '0 : out_head;
  end

  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (clear_i) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (push_pend_q & in_full & ~in_pop) overrun_d  = 1'b1;
    if (tx_load & out_empty)             underrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      push_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      push_pend_q <= push_pend_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign spi_sdo_o    = (state_q == ACTIVE) & tx_q[PIXEL_BITS-1];
  assign spi_sdo_oe_o = ~cs_s;
  assign px_valid_o   = ~in_empty;
  assign res_ready_o  = ~out_full;
  assign overrun_o    = overrun_q;
  assign underrun_o   = underrun_q;
  assign in_level_o   = in_level;
  assign out_level_o  = out_level;

endmodule

// File: tb/tb_spi_pixel_bridge.sv
// Directed and randomized SPI frames checked against a word-level queue model of the bridge.
module tb_spi_pixel_bridge;

  localparam int PB      = 24;
  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int HALF    = 8;
  localparam int LAT_MAX = SYNC + 3;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          sck = 1'b0, cs = 1'b1, sdi = 1'b0;
  logic          pxReady = 1'b0, resValid = 1'b0, clear = 1'b0;
  logic [PB-1:0] res = '0;
  logic          sdo, sdoOe, pxValid, resReady, overrun, underrun;
  logic [PB-1:0] px;
  logic [2:0]    inLevel, outLevel;

  logic [PB-1:0] outQ[$], inQ[$];
  logic          expOverrun = 1'b0, expUnderrun = 1'b0;
  logic [PB-1:0] txWord = '0, rxWord = '0;
  logic [PB-1:0] frameWords[6];
  int            checks = 0, errors = 0;

  spi_pixel_bridge dut (
    .clk_i(clk), .nreset_i(nreset),
    .spi_sck_i(sck), .spi_cs_i(cs), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .spi_sdo_oe_o(sdoOe),
    .px_o(px), .px_valid_o(pxValid), .px_ready_i(pxReady),
    .res_i(res), .res_valid_i(resValid), .res_ready_o(resReady),
    .clear_i(clear), .overrun_o(overrun), .underrun_o(underrun),
    .in_level_o(inLevel), .out_level_o(outLevel));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic modelLoadTx();
    if (outQ.size() > 0) txWord = outQ.pop_front();
    else begin
      txWord      = '0;
      expUnderrun = 1'b1;
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rstPx", px, 0);
    checkOutput("rstPxValid", pxValid, 0);
    checkOutput("rstResReady", resReady, 1);
    checkOutput("rstSdo", sdo, 0);
    checkOutput("rstSdoOe", sdoOe, 0);
    checkOutput("rstOverrun", overrun, 0);
    checkOutput("rstUnderrun", underrun, 0);
    checkOutput("rstInLevel", inLevel, 0);
    checkOutput("rstOutLevel", outLevel, 0);
  endtask

  task automatic checkFlags();
    checkOutput("overrun", overrun, expOverrun);
    checkOutput("underrun", underrun, expUnderrun);
    checkOutput("inLevel", inLevel, inQ.size());
    checkOutput("outLevel", outLevel, outQ.size());
  endtask

  task automatic clearFlags();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expOverrun  = 1'b0;
    expUnderrun = 1'b0;
    tick(1);
    checkOutput("clearOverrun", overrun, 0);
    checkOutput("clearUnderrun", underrun, 0);
  endtask

  task automatic pushResult(input logic [PB-1:0] w);
    logic accept;
    accept   = (outQ.size() < DEPTH);
    res      = w;
    resValid = 1'b1;
    checkOutput("resReady", resReady, accept);
    tick(1);
    if (accept) outQ.push_back(w);
    resValid = 1'b0;
    tick(1);
  endtask

  task automatic drainAll();
    while (inQ.size() > 0) begin
      checkOutput("pxValid", pxValid, 1);
      checkOutput("pxData", px, inQ.pop_front());
      pxReady = 1'b1;
      tick(1);
      pxReady = 1'b0;
    end
    checkOutput("pxValidEmpty", pxValid, 0);
    checkOutput("inLevelEmpty", inLevel, 0);
  endtask

  // Drives one CS frame of nbits taken MSB-first from frameWords; optionally leaves CS low.
  task automatic applyStimulus(input int nbits, input bit endFrame);
    int   pos, lat;
    logic b, seen, measure;
    cs = 1'b0;
    modelLoadTx();
    tick(HALF);
    checkOutput("outLevelAtCsFall", outLevel, outQ.size());
    checkOutput("sdoOe", sdoOe, 1);
    for (int i = 0; i < nbits; i++) begin
      pos = i % PB;
      b   = frameWords[i / PB][PB-1-pos];
      sdi = b;
      tick(HALF);
      checkOutput("sdoBit", sdo, txWord[PB-1-pos]);
      measure = (pos == PB - 1) && (inQ.size() == 0) && !pxReady;
      sck     = 1'b1;
      rxWord  = {rxWord[PB-2:0], b};
      seen    = 1'b0;
      lat     = 0;
      for (int c = 1; c <= HALF; c++) begin
        @(posedge clk);
        #1;
        if (!seen && pxValid) begin
          seen = 1'b1;
          lat  = c;
        end
      end
      if (pos == PB - 1) begin
        if (inQ.size() < DEPTH) inQ.push_back(rxWord);
        else expOverrun = 1'b1;
        if (measure) checkOutput("latency", (seen && lat <= LAT_MAX), 1);
      end
      sck = 1'b0;
      if (pos == PB - 1) modelLoadTx();
    end
    tick(HALF);
    if (endFrame) begin
      cs = 1'b1;
      tick(HALF);
    end
  endtask

  initial begin
    int nres, nw;

    tick(3);
    checkResetValues();
    nreset = 1'b1;
    tick(3);

    $display("[TB] single pixel");
    pushResult($urandom());
    pushResult($urandom());
    frameWords[0] = 24'hA5C33C;
    applyStimulus(PB, 1);
    checkFlags();
    checkOutput("singleOverrun", overrun, 0);
    checkOutput("singleUnderrun", underrun, 0);
    pxReady = 1'b1;
    checkOutput("singlePx", px, 24'hA5C33C);
    tick(1);
    pxReady = 1'b0;
    void'(inQ.pop_front());
    checkOutput("singleInLevel", inLevel, 0);
    checkOutput("singleValidGone", pxValid, 0);

    $display("[TB] loopback");
    pushResult(24'h123456);
    checkOutput("loopOutLevel", outLevel, 1);
    frameWords[0] = $urandom();
    applyStimulus(PB, 1);
    checkFlags();
    drainAll();
    clearFlags();

    $display("[TB] overrun");
    for (int k = 0; k < 5; k++) frameWords[k] = $urandom();
    applyStimulus(5 * PB, 1);
    checkFlags();
    checkOutput("ovrLevel", inLevel, 4);
    checkOutput("ovrFlag", overrun, 1);
    drainAll();
    clearFlags();

    $display("[TB] underrun back-to-back");
    pushResult(24'hABCDEF);
    frameWords[0] = $urandom();
    frameWords[1] = $urandom();
    applyStimulus(2 * PB, 1);
    checkFlags();
    checkOutput("udrFlag", underrun, 1);
    drainAll();
    clearFlags();

    $display("[TB] abort");
    frameWords[0] = $urandom();
    applyStimulus(10, 1);
    frameWords[0] = 24'h00FF00;
    applyStimulus(PB, 1);
    checkFlags();
    checkOutput("abortLevel", inLevel, 1);
    drainAll();
    clearFlags();

    $display("[TB] output fifo full");
    for (int k = 0; k < 5; k++) pushResult($urandom());
    checkOutput("outFull", outLevel, 4);
    for (int k = 0; k < 3; k++) frameWords[k] = $urandom();
    applyStimulus(3 * PB, 1);
    checkFlags();
    drainAll();
    clearFlags();

    $display("[TB] reset mid-frame");
    frameWords[0] = $urandom();
    applyStimulus(12, 0);
    nreset = 1'b0;
    tick(2);
    checkResetValues();
    cs  = 1'b1;
    sck = 1'b0;
    tick(2);
    nreset = 1'b1;
    inQ.delete();
    outQ.delete();
    expOverrun  = 1'b0;
    expUnderrun = 1'b0;
    tick(4);
    frameWords[0] = 24'h0F0F0F;
    applyStimulus(PB, 1);
    checkFlags();
    checkOutput("rstFrameLevel", inLevel, 1);
    checkOutput("rstFramePx", px, 24'h0F0F0F);
    drainAll();
    clearFlags();

    $display("[TB] random frames");
    for (int it = 0; it < 6; it++) begin
      nres = $urandom_range(0, 3);
      for (int k = 0; k < nres; k++) pushResult($urandom());
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) frameWords[k] = $urandom();
      applyStimulus(nw * PB, 1);
      checkFlags();
      drainAll();
      clearFlags();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_pixel_bridge.md
Name: spi_pixel_bridge

Overview:
Parametrised SPI-slave pixel bridge that replaces the fixed-width, unbuffered SPI pixel link between the chip pins and the image-processing core.
- Receives PIXEL_BITS-wide pixels over SPI mode 0 and queues them in an input FIFO toward the core.
- Queues core results in an output FIFO and streams them back on SDO in the same full-duplex transfer.
- Adds valid/ready handshakes, FIFO depth and sticky overrun/underrun status, none of which the previous link had.

Parameters:
PIXEL_BITS, 24, bits per pixel word on SPI and on both core interfaces.
FIFO_DEPTH, 4, entries per FIFO (power of two, >=2).
SYNC_STAGES, 2, synchroniser flops on SCK/CS/SDI (>=2).

Ports:
clk_i  input  1  system clock; must be >= 4x SCK frequency.
nreset_i  input  1  asynchronous active-low reset.
spi_sck_i  input  1  SPI clock, idles low (mode 0).
spi_cs_i  input  1  chip select, active low.
spi_sdi_i  input  1  serial data in, MSB first.
spi_sdo_o  output  1  serial data out, MSB first.
spi_sdo_oe_o  output  1  high while synchronised CS is low.
px_o  output  PIXEL_BITS  input-FIFO head toward core.
px_valid_o  output  1  input FIFO non-empty.
px_ready_i  input  1  core accepts px_o; pop on valid&ready.
res_i  input  PIXEL_BITS  core result word.
res_valid_i  input  1  result present.
res_ready_o  output  1  output FIFO not full; push on valid&ready.
clear_i  input  1  single-cycle pulse clearing sticky flags.
overrun_o  output  1  sticky: received word dropped, input FIFO full.
underrun_o  output  1  sticky: word boundary with output FIFO empty.
in_level_o  output  $clog2(FIFO_DEPTH+1)  input FIFO occupancy.
out_level_o  output  $clog2(FIFO_DEPTH+1)  output FIFO occupancy.

Behaviour:
- Reset: all outputs 0 except res_ready_o=1; both FIFOs empty; state IDLE; bit counter 0; sticky flags 0. Reset asserted mid-transfer aborts the transfer. The partial word is lost and the bridge waits in IDLE for a fresh CS falling edge.
- SCK, CS and SDI each pass through SYNC_STAGES flops. Rise/fall events come from the last two synchronised SCK samples and are ignored unless CS is low.
- FSM IDLE: SDO=0. Synchronised CS falling moves the FSM to ACTIVE in the same cycle, sets bit_cnt=0 and loads the TX word.
- TX word load: pop the output-FIFO head if non-empty. If empty, load all-zeros and set underrun_o. SDO = TX MSB.
- ACTIVE, SCK rise: shift SDI into the RX LSB and increment bit_cnt.
  - When bit_cnt reaches PIXEL_BITS it wraps to 0. On the next cycle the RX word is pushed to the input FIFO.
  - If the FIFO is full, the word is dropped, overrun_o is set and FIFO contents are unchanged.
- ACTIVE, SCK fall: if bit_cnt==0, load the next TX word (rule above); otherwise shift TX left and SDO = new MSB.
- ACTIVE, CS rising: return to IDLE. A partial RX word (bit_cnt!=0) is discarded with no push; the popped TX word is discarded.
- Input latency: px_valid_o rises <= SYNC_STAGES+3 clk after the final SCK rising edge at the pin.
- FIFO, simultaneous push and pop:
  - Full: the pop frees space first, the push succeeds, level is unchanged, no overrun.
  - Empty: the pop is ignored and the push succeeds.
- Output FIFO: res_ready_o = !full, registered from the level. Pop at a TX load and core push in the same cycle follow the same rules.
- clear_i clears both sticky flags. If a set event coincides, set wins.
- Data is never reordered; FIFO pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package spi_bridge_pkg: default PIXEL_BITS/FIFO_DEPTH/SYNC_STAGES constants, bridge_state_t enum {IDLE, ACTIVE}, level width function.
- Sub-module pixel_fifo (WIDTH, DEPTH; push/pop/full/empty/level, pop-before-push on full), instantiated twice.
- The synchroniser is reused from the existing common synchroniser cell.

Test Plan:
- Single pixel (defaults): CS low, shift 0xA5C33C, px_ready_i=1 -> px_o=0xA5C33C one-cycle valid within latency bound; in_level_o back to 0; no flags set.
- Loopback: push res_i=0x123456 with CS high, then 24-bit transfer -> SDO bits MSB-first equal 0x123456; out_level_o 1->0 at CS fall.
- Overrun: 5 words with px_ready_i=0 -> in_level_o=4, overrun_o=1; reads return the first 4 words in order; 5th absent; clear_i -> overrun_o=0.
- Underrun plus back-to-back: two words in one CS frame, output FIFO holding only 0xABCDEF -> SDO=0xABCDEF then 24 zeros; underrun_o=1 at word 2 boundary.
- Abort: CS rises after 10 bits, then full frame 0x00FF00 -> only 0x00FF00 pushed; in_level_o=1.
- Reset mid-frame after 12 bits, then full frame 0x0F0F0F -> all outputs at reset values while nreset_i=0; afterwards only 0x0F0F0F received.
